// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Two-of-three vote used to reject single-sample line glitches.
   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_in,
   output logic q_out
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d_in;
         r_sync <= r_meta;
      end
   end

   assign q_out = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronised input, 3-sample majority vote, one-cycle byte
// and framing-error strobes.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 25
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] data_out,
   output logic                      valid_out,
   output logic                      framing_error_out,
   output logic                      busy_out
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);

   logic                      w_rx_s;
   logic                      w_maj;
   logic [2:0]                r_hist;
   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]          r_cyc_cnt;
   logic [CNT_W-1:0]          w_cyc_nxt;
   logic [BIT_W-1:0]          r_bit_cnt;
   logic [BIT_W-1:0]          w_bit_nxt;
   logic [UART_DATA_BITS-1:0] r_shreg;
   logic [UART_DATA_BITS-1:0] w_shreg_nxt;
   logic [UART_DATA_BITS-1:0] r_data;
   logic [UART_DATA_BITS-1:0] w_data_nxt;
   logic                      r_valid;
   logic                      w_valid_nxt;
   logic                      r_ferr;
   logic                      w_ferr_nxt;
   logic                      r_busy;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d_in   (rx_in),
      .q_out  (w_rx_s)
   );

   assign w_maj = maj3(r_hist);

   // History of the synchronised line feeding the majority vote.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_hist <= 3'b111;
      end else begin
         r_hist <= {r_hist[1:0], w_rx_s};
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, counters, shift register and output strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_cyc_cnt + CNT_W'(1);
      w_bit_nxt   = r_bit_cnt;
      w_shreg_nxt = r_shreg;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_cyc_nxt = '0;
            w_bit_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt = START;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         START: begin
            if (r_cyc_cnt == HALF_LAST) begin
               w_cyc_nxt = '0;
               if (w_maj) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
               end
            end else begin
               w_state_nxt = START;
            end
         end
         DATA: begin
            if (r_cyc_cnt == BIT_LAST) begin
               w_cyc_nxt   = '0;
               w_shreg_nxt = {w_maj, r_shreg[UART_DATA_BITS-1:1]};
               if (r_bit_cnt == DATA_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit_cnt + BIT_W'(1);
               end
            end else begin
               w_state_nxt = DATA;
            end
         end
         STOP: begin
            // Leaving at mid-stop lets a following start bit be caught with no idle gap.
            if (r_cyc_cnt == BIT_LAST) begin
               w_cyc_nxt = '0;
               if (w_maj) begin
                  w_data_nxt  = r_shreg;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = BREAK;
               end
            end else begin
               w_state_nxt = STOP;
            end
         end
         BREAK: begin
            w_cyc_nxt = '0;
            if (w_rx_s) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = BREAK;
            end
         end
         default: begin
            w_cyc_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_cyc_cnt <= '0;
         r_bit_cnt <= '0;
         r_shreg   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_cyc_cnt <= w_cyc_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shreg   <= w_shreg_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_ferr    <= w_ferr_nxt;
         r_busy    <= (w_state_nxt != IDLE);
      end
   end

   assign data_out          = r_data;
   assign valid_out         = r_valid;
   assign framing_error_out = r_ferr;
   assign busy_out          = r_busy;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frames are queued as they are sent and a
// negedge monitor checks every strobe for kind, data and cycle-exact latency.
module tb_uart_byte_rx;

   localparam int CPB = 25;
   localparam int H   = CPB / 2;
   localparam int LAT = 2 + H + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       framing_error_out;
   logic       busy_out;

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .rx_in             (rx),
      .data_out          (data_out),
      .valid_out         (valid_out),
      .framing_error_out (framing_error_out),
      .busy_out          (busy_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] last_good = 8'h00;
   bit         prev_pulse = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_pulse = 1'b0;
      end else begin
         if (valid_out || framing_error_out) begin
            check("pulse_exclusive", {31'd0, valid_out & framing_error_out}, 32'd0);
            check("pulse_not_repeated", {31'd0, prev_pulse}, 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_pulse", {30'd0, valid_out, framing_error_out}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("pulse_kind_is_err", {31'd0, framing_error_out}, {31'd0, e.is_err});
               check("latency_cycle", cyc, e.at);
               if (e.is_err) begin
                  check("data_held_on_ferr", {24'd0, data_out}, {24'd0, last_good});
               end else begin
                  check("data_out", {24'd0, data_out}, {24'd0, e.data});
                  last_good = e.data;
               end
            end
         end
         prev_pulse = valid_out || framing_error_out;
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends one frame; called just after a posedge, returns just after a posedge.
   task automatic send_frame(input logic [7:0] b, input int cpb, input bit stop_bit,
                             input bit spike, input bit expect_it, input bit is_err);
      logic [9:0] bits;
      int         n0;
      int         k;
      int         off;
      bits = {stop_bit, b, 1'b0};
      n0   = cyc;
      if (expect_it) sb.push_back('{is_err, b, n0 + LAT});
      for (int t = 0; t < 10 * cpb; t++) begin
         k   = t / cpb;
         off = H + k * CPB - 2;
         if (spike && t == off) rx = ~bits[k];
         else rx = bits[k];
         tick(1);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 4000) begin
         tick(1);
         n++;
      end
      check(name, sb.size(), 32'd0);
      tick(3);
   endtask

   initial begin
      #200_0000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq[$];
      tick(4);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_ferr", {31'd0, framing_error_out}, 32'd0);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      rst = 1'b0;
      tick(20);

      // 1: single byte after idle
      send_frame(8'h36, CPB, 1'b1, 1'b0, 1'b1, 1'b0);
      drain("t1_drain");
      check("t1_busy_after", {31'd0, busy_out}, 32'd0);

      // 2: 24 back-to-back bytes
      for (int i = 0; i < 3; i++) seq.push_back(8'h00);
      for (int i = 0; i < 8; i++) seq.push_back(8'h36);
      for (int i = 0; i < 8; i++) seq.push_back(8'h37);
      for (int i = 0; i < 5; i++) seq.push_back(8'h38);
      foreach (seq[i]) send_frame(seq[i], CPB, 1'b1, 1'b0, 1'b1, 1'b0);
      drain("t2_drain");

      // 3: 6-cycle low glitch is a false start
      rx = 1'b0;
      tick(6);
      check("t3_busy_in_start", {31'd0, busy_out}, 32'd1);
      rx = 1'b1;
      tick(30);
      check("t3_busy_back_idle", {31'd0, busy_out}, 32'd0);
      send_frame(8'hA5, CPB, 1'b1, 1'b0, 1'b1, 1'b0);
      drain("t3_drain");

      // 4: framing error, long break, then recovery
      send_frame(8'h55, CPB, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(40);
      check("t4_busy_in_break", {31'd0, busy_out}, 32'd1);
      rx = 1'b1;
      tick(30);
      check("t4_busy_after_break", {31'd0, busy_out}, 32'd0);
      send_frame(8'h3C, CPB, 1'b1, 1'b0, 1'b1, 1'b0);
      drain("t4_drain");

      // 5: reset in the middle of data bit 4 of 0xFF
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(4 * CPB + H);
      rst = 1'b1;
      last_good = 8'h00;
      #1;
      check("t5_rst_data", {24'd0, data_out}, 32'd0);
      check("t5_rst_busy", {31'd0, busy_out}, 32'd0);
      check("t5_rst_valid", {31'd0, valid_out}, 32'd0);
      tick(3);
      rst = 1'b0;
      tick(150);
      check("t5_idle_after_rst", {31'd0, busy_out}, 32'd0);
      send_frame(8'h81, CPB, 1'b1, 1'b0, 1'b1, 1'b0);
      drain("t5_drain");

      // 6: baud mismatch with a spike at every sample point
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) begin
            send_frame(8'($urandom_range(0, 255)), (r == 0) ? 24 : 26, 1'b1, 1'b1, 1'b1, 1'b0);
         end
         tick(30);
         drain("t6_drain");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
